jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Shares one bank of WIDTH JK-style storage bits among NREQ requesters.
- Each requester posts a 2-bit JK command plus a target bit index.
- A round-robin arbiter picks one requester per clock and applies its command to the addressed bit.
- Sits between control FSMs that need flag/toggle bits and the shared flag register they read back.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK bits in the bank.
- IDXW, 3, width of each bit index; must satisfy 2**IDXW >= WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request, level.
- cmd  in  2*NREQ  requester i command at [2i+1:2i]: 00 HOLD, 01 SET, 10 RESET, 11 TOGGLE.
- idx  in  NREQ*IDXW  requester i target bit at [IDXW*i+IDXW-1:IDXW*i].
- gnt  out  NREQ  registered one-hot grant; one-cycle pulse per service.
- q  out  WIDTH  bank contents, registered.
- qn  out  WIDTH  ~q, combinational.
- err  out  1  registered one-cycle pulse: the served command had idx >= WIDTH.
- busy  out  1  combinational OR of req.

Behaviour:
- Reset (rst=1 at posedge): q=0, gnt=0, err=0, rr pointer ptr=0. rst overrides all requests.
- Arbitration, each posedge with rst=0:
  - Search req starting at index ptr, ascending, wrapping at NREQ-1 to 0.
  - The first asserted index is the winner w.
  - If no req is asserted: gnt<=0, err<=0, ptr unchanged, q unchanged.
- Service of w:
  - gnt<=onehot(w).
  - ptr<=(w+1) mod NREQ.
  - Bit q[idx_w] is updated per cmd_w: HOLD keeps the bit, SET writes 1, RESET writes 0, TOGGLE inverts it.
  - All other bits hold.
- Latency: command is applied at the same edge that registers gnt; new q is visible together with gnt, one cycle after sampling.
- Out-of-range idx_w >= WIDTH:
  - No bit changes.
  - Grant is still issued and ptr still advances.
  - err<=1 for one cycle.
- Handshake:
  - A requester holds req, cmd and idx stable until it sees gnt[i]=1.
  - It deasserts req in that same cycle, or the command is treated as a new request and is re-served on its next turn.
  - A TOGGLE left asserted therefore toggles again on each turn; this is intended.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once every NREQ cycles.
- Simultaneous requests targeting the same bit: only the winner's command applies that cycle; the others wait. No merging of commands.
- At most one gnt bit is ever high.

Optional Feature:
- Macro JK_BANK_ARB_PRIO_EN.
- Defined: fixed priority. The lowest asserted index always wins, ptr is not used, and starvation is allowed.
- Undefined: round-robin as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package jk_bank_pkg holds:
  - command constants CMD_HOLD=2'b00, CMD_SET=2'b01, CMD_RESET=2'b10, CMD_TOGGLE=2'b11;
  - a function applying a command to one bit value.
- One combinational sub-module jk_rr_pick (inputs req, ptr; outputs winner index and valid) isolates the wrap-around search. Its fixed-priority variant is selected by the macro.

Test Plan:
1. Reset then idle:
   - Stimulus: rst=1 for 2 cycles, then req=0 for 5 cycles.
   - Required: q=8'h00, qn=8'hFF, gnt=0, err=0 throughout.
2. Single requester:
   - Stimulus: req[2] with SET idx=5, dropped on gnt; then TOGGLE idx=5, then TOGGLE idx=0.
   - Required: after each grant, q=8'h20, then q=8'h00, then q=8'h01. gnt=4'b0100 exactly once per command.
3. Round-robin with all requesters held:
   - Stimulus: req=4'b1111 held for 8 cycles, each requester cmd TOGGLE on idx=i.
   - Required: gnt sequence 0001,0010,0100,1000,0001,...; q reaches 8'h0F after 4 grants and 8'h00 after 8.
4. Same-bit conflict:
   - Stimulus: req0 SET idx=3 and req1 RESET idx=3 asserted together with ptr=0, each dropped on its own gnt.
   - Required: q[3]=1 on the first grant, q[3]=0 on the next.
5. Out-of-range index:
   - Stimulus: WIDTH=6, req3 SET idx=7.
   - Required: gnt=4'b1000, err=1 for one cycle, q unchanged.
6. Reset mid-operation:
   - Stimulus: q=8'hA5 with req=4'b1111 active, then rst=1 for one cycle.
   - Required: next cycle q=0 and gnt=0; first grant after release goes to requester 0.
   - Repeat with JK_BANK_ARB_PRIO_EN defined: requester 0 wins every cycle while req[0]=1.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// JK command encoding shared by the bank arbiter and its requesters,
// plus the single-bit command application used by the bank update.
package jk_bank_pkg;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_SET    = 2'b01;
  localparam logic [1:0] CMD_RESET  = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  function automatic logic jk_apply(input logic bit_q, input logic [1:0] jk_cmd);
    logic r;
    case (jk_cmd)
      CMD_HOLD:   r = bit_q;
      CMD_SET:    r = 1'b1;
      CMD_RESET:  r = 1'b0;
      CMD_TOGGLE: r = ~bit_q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_rr_pick.sv
// Combinational winner search: round-robin from ptr, wrapping at NREQ-1.
// JK_BANK_ARB_PRIO_EN selects fixed priority (lowest index wins, ptr ignored).
module jk_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            vld
);

`ifdef JK_BANK_ARB_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    win = '0;
    vld = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) win = PW'(k);
    end
  end
`else
  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    win = '0;
    vld = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [PW-1:0] c;
      c = PW'((int'(ptr) + k) % NREQ);
      if (req[c]) win = c;
    end
  end
`endif

endmodule

// File: rtl/jk_bank_arbiter.sv
// Shared JK flag bank: one requester served per clock, result and gnt registered together (1 cycle);
// losers wait with req held. JK_BANK_ARB_PRIO_EN switches round-robin to fixed priority.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    cmd,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic                 err,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_q;
  logic             r_err;

  logic [PW-1:0]    w_win;
  logic             w_vld;
  logic [1:0]       w_cmd;
  logic [IDXW-1:0]  w_idx;
  logic             w_oob;
  logic [WIDTH-1:0] w_q_nxt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [PW-1:0]    w_ptr_nxt;

  jk_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .win (w_win),
    .vld (w_vld)
  );

  always_comb begin
    w_cmd = CMD_HOLD;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_cmd = cmd[2*i +: 2];
        w_idx = idx[IDXW*i +: IDXW];
      end
    end
  end

  assign w_oob = int'(w_idx) >= WIDTH;

  // Out-of-range targets still consume the grant but leave the bank untouched.
  always_comb begin
    w_q_nxt = r_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (w_vld && !w_oob && (w_idx == IDXW'(b))) w_q_nxt[b] = jk_apply(r_q[b], w_cmd);
    end
  end

  assign w_gnt_nxt = w_vld ? (NREQ'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_gnt <= '0;
      r_err <= 1'b0;
      r_ptr <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_gnt <= w_gnt_nxt;
      r_err <= w_vld && w_oob;
      if (w_vld) r_ptr <= w_ptr_nxt;
    end
  end

  assign q    = r_q;
  assign qn   = ~r_q;
  assign gnt  = r_gnt;
  assign err  = r_err;
  assign busy = |req;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-free behavioural model.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    cmd;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qn;
  logic                 err;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  logic             m_err;
  int               m_ptr;
  bit               m_vld = 1'b0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .idx  (idx),
    .gnt  (gnt),
    .q    (q),
    .qn   (qn),
    .err  (err),
    .busy (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what the bank, grant and error must be right after each edge.
  always @(posedge clk) begin
    int w;
    w = -1;
    if (rst) begin
      m_q   = '0;
      m_gnt = '0;
      m_err = 1'b0;
      m_ptr = 0;
      m_vld = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
`ifdef JK_BANK_ARB_PRIO_EN
        c = k;
`else
        c = (m_ptr + k) % NREQ;
`endif
        if (w < 0 && req[c]) w = c;
      end
      m_gnt = '0;
      m_err = 1'b0;
      if (w >= 0) begin
        int b;
        int c2;
        b  = idx[IDXW*w +: IDXW];
        c2 = cmd[2*w +: 2];
        m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % NREQ;
        if (b >= WIDTH) m_err = 1'b1;
        else if (c2 == 1) m_q[b] = 1'b1;
        else if (c2 == 2) m_q[b] = 1'b0;
        else if (c2 == 3) m_q[b] = ~m_q[b];
      end
    end
  end

  always @(negedge clk) begin
    logic [WIDTH-1:0] e_qn;
    if (m_vld) begin
      e_qn = ~m_q;
      chk("gnt", gnt, m_gnt);
      chk("q", q, m_q);
      chk("qn", qn, e_qn);
      chk("err", err, m_err);
      chk("busy", busy, |req);
      chk("gnt_onehot", ($countones(gnt) <= 1), 1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic post(input int i, input logic [1:0] c, input int b);
    req[i] = 1'b1;
    cmd[2*i +: 2] = c;
    idx[IDXW*i +: IDXW] = IDXW'(b);
  endtask

  task automatic serve(input int i);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      cyc();
      if (m_gnt[i]) got = 1'b1;
    end
    chk("serve_timeout", got, 1);
    req[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    cmd = '0;
    idx = '0;

    // Reset then idle
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t1_q", q, 8'h00);
      chk("t1_qn", qn, 8'hFF);
      chk("t1_gnt", gnt, 0);
      chk("t1_err", err, 0);
    end

    // Single requester
    post(2, 2'b01, 5);
    serve(2);
    chk("t2_q_set", q, 8'h20);
    chk("t2_gnt", gnt, 4'b0100);
    cyc();
    chk("t2_gnt_once", gnt, 0);
    post(2, 2'b11, 5);
    serve(2);
    chk("t2_q_tog5", q, 8'h00);
    post(2, 2'b11, 0);
    serve(2);
    chk("t2_q_tog0", q, 8'h01);
    cyc();

    // All requesters held, toggling their own bit
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) post(i, 2'b11, i);
    for (int k = 0; k < 8; k++) begin
      cyc();
`ifdef JK_BANK_ARB_PRIO_EN
      chk("t3_gnt", gnt, 4'b0001);
      if (k == 3) chk("t3_q4", q, 8'h00);
`else
      chk("t3_gnt", gnt, 4'b0001 << (k % 4));
      if (k == 3) chk("t3_q4", q, 8'h0F);
`endif
      if (k == 7) chk("t3_q8", q, 8'h00);
    end
    req = '0;
    cyc();

    // Same-bit conflict
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    post(0, 2'b01, 3);
    post(1, 2'b10, 3);
    cyc();
    chk("t4_gnt0", gnt, 4'b0001);
    chk("t4_q3_set", q[3], 1);
    req[0] = 1'b0;
    cyc();
    chk("t4_gnt1", gnt, 4'b0010);
    chk("t4_q3_rst", q[3], 0);
    req[1] = 1'b0;

    // Out-of-range index
    post(3, 2'b01, 11);
    serve(3);
    chk("t5_gnt", gnt, 4'b1000);
    chk("t5_err", err, 1);
    chk("t5_q", q, 8'h00);
    cyc();
    chk("t5_err_pulse", err, 0);

    // Reset mid-operation
    post(0, 2'b01, 0); serve(0);
    post(0, 2'b01, 2); serve(0);
    post(0, 2'b01, 5); serve(0);
    post(0, 2'b01, 7); serve(0);
    chk("t6_qA5", q, 8'hA5);
    for (int i = 0; i < NREQ; i++) post(i, 2'b00, i);
    cyc();
    chk("t6_hold", q, 8'hA5);
    rst = 1'b1;
    cyc();
    chk("t6_rst_q", q, 8'h00);
    chk("t6_rst_gnt", gnt, 0);
    rst = 1'b0;
    cyc();
    chk("t6_first", gnt, 4'b0001);
    cyc();
`ifdef JK_BANK_ARB_PRIO_EN
    chk("t6_second", gnt, 4'b0001);
`else
    chk("t6_second", gnt, 4'b0010);
`endif
    req = '0;
    cyc();

    // Randomized traffic with occasional reset and re-served held requests
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_gnt[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 1) == 1)
          post(i, 2'($urandom_range(0, 3)), $urandom_range(0, 9));
      end
      cyc();
    end

    rst = 1'b0;
    req = '0;
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
